// File: rtl/hidden_layer_mac_pkg.sv
// Shared types and helpers for the layer-1 hidden-neuron MAC engine:
// FSM state encoding, index-width helper and ReLU/requantise/saturate.
package hidden_layer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Index width with a floor of one bit, so a single-entry range still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // ReLU, arithmetic right shift, then clamp to an unsigned dw-bit range.
  function automatic logic [63:0] relu_requant(input logic signed [63:0] acc,
                                               input int unsigned shift,
                                               input int unsigned dw);
    logic signed [63:0] shifted;
    logic        [63:0] max_v;
    max_v   = (64'd1 << dw) - 64'd1;
    shifted = acc >>> shift;
    if (acc < 0)                     return '0;
    else if ($unsigned(shifted) > max_v) return max_v;
    else                             return $unsigned(shifted);
  endfunction

endpackage

// File: rtl/hidden_layer_mac_if.sv
// Control, memory read ports and activation stream of the hidden-layer MAC.
// The engine connects through slave; the surrounding system through master.
interface hidden_layer_mac_if #(
  parameter int INPUT_SIZE  = 4096,
  parameter int HIDDEN_SIZE = 128,
  parameter int DATA_WIDTH  = 8
);
  localparam int XA_W = hidden_layer_pkg::idx_width(INPUT_SIZE);
  localparam int WA_W = hidden_layer_pkg::idx_width(INPUT_SIZE * HIDDEN_SIZE);
  localparam int HI_W = hidden_layer_pkg::idx_width(HIDDEN_SIZE);

  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [XA_W-1:0]       x_addr;
  logic [WA_W-1:0]       w_addr;
  logic [DATA_WIDTH-1:0] x_data;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  h_valid;
  logic                  h_ready;
  logic [DATA_WIDTH-1:0] h_data;
  logic [HI_W-1:0]       h_index;

  modport slave (
    input  start, x_data, w_data, h_ready,
    output busy, done, rd_en, x_addr, w_addr, h_valid, h_data, h_index
  );

  modport master (
    output start, x_data, w_data, h_ready,
    input  busy, done, rd_en, x_addr, w_addr, h_valid, h_data, h_index
  );
endinterface

// File: rtl/hidden_layer_mac_mac_unit.sv
// Registered signed multiply-accumulate: unsigned pixel times signed weight,
// with synchronous clear taking priority over enable.
module mac_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        en_i,
  input  logic [DATA_WIDTH-1:0]       a_i,
  input  logic [DATA_WIDTH-1:0]       b_i,
  output logic signed [ACC_WIDTH-1:0] acc_o
);
  localparam int PW = 2 * DATA_WIDTH + 1;

  logic signed [PW-1:0]        a_ext, b_ext, prod;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

  assign a_ext = $signed({{(DATA_WIDTH + 1){1'b0}}, a_i});
  assign b_ext = $signed({{(DATA_WIDTH + 1){b_i[DATA_WIDTH-1]}}, b_i});
  assign prod  = a_ext * b_ext;

  always_comb begin
    // NOTE: default assignment first, so every path drives acc_d and no latch is inferred.
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + ACC_WIDTH'(prod);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register samples pre-edge values.
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/hidden_layer_mac.sv
// Layer-1 compute stage: one neuron at a time, one MAC per cycle over all
// pixels, then ReLU/shift/saturate and hand the activation to layer 2.
module hidden_layer_mac
  import hidden_layer_pkg::*;
#(
  parameter int INPUT_SIZE  = 4096,
  parameter int HIDDEN_SIZE = 128,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int SHIFT       = 7
) (
  input logic               clk,
  input logic               rst,
  hidden_layer_mac_if.slave bus
);
  localparam int XA_W = idx_width(INPUT_SIZE);
  localparam int WA_W = idx_width(INPUT_SIZE * HIDDEN_SIZE);
  localparam int HI_W = idx_width(HIDDEN_SIZE);

  state_e                      state_q, state_d;
  logic [XA_W-1:0]             k_q, k_d;
  logic [HI_W-1:0]             n_q, n_d;
  logic                        mac_en_q;
  logic                        acc_clr;
  logic signed [ACC_WIDTH-1:0] acc;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    acc_clr = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = RUN;
        k_d     = '0;
        n_d     = '0;
        acc_clr = 1'b1;
      end
      RUN: begin
        k_d = k_q + XA_W'(1);
        if (k_q == XA_W'(INPUT_SIZE - 1)) begin
          k_d     = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: state_d = EMIT;
      EMIT: if (bus.h_ready) begin
        acc_clr = 1'b1;
        k_d     = '0;
        if (n_q == HI_W'(HIDDEN_SIZE - 1)) begin
          state_d = DONE;
        end else begin
          n_d     = n_q + HI_W'(1);
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mac_en_q tracks the one-cycle read latency; dropping it on reset discards in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      n_q      <= '0;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      n_q      <= n_d;
      mac_en_q <= (state_q == RUN);
    end
  end

  mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr_i(acc_clr),
    .en_i (mac_en_q),
    .a_i  (bus.x_data),
    .b_i  (bus.w_data),
    .acc_o(acc)
  );

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.rd_en   = (state_q == RUN);
  assign bus.x_addr  = (state_q == RUN) ? k_q : '0;
  assign bus.w_addr  = (state_q == RUN)
                     ? WA_W'(k_q) * WA_W'(HIDDEN_SIZE) + WA_W'(n_q) : '0;
  // acc and n are frozen throughout EMIT, so data/index hold steady under backpressure.
  assign bus.h_valid = (state_q == EMIT);
  assign bus.h_index = (state_q == EMIT) ? n_q : '0;
  assign bus.h_data  = (state_q == EMIT)
                     ? DATA_WIDTH'(relu_requant(64'($signed(acc)), SHIFT, DATA_WIDTH)) : '0;
endmodule

// File: tb/tb_hidden_layer_mac.sv
// Directed bench: two engines (SHIFT=0 and SHIFT=4) over shared 1-cycle-latency
// pixel/weight memories, INPUT_SIZE=4, HIDDEN_SIZE=2.
module tb_hidden_layer_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_s = 1'b0;
  logic ready_s = 1'b0;
  logic sel     = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] pix [4];
  logic [7:0] wt  [8];

  always #5 clk = ~clk;

  hidden_layer_mac_if #(.INPUT_SIZE(4), .HIDDEN_SIZE(2), .DATA_WIDTH(8)) bus0 ();
  hidden_layer_mac_if #(.INPUT_SIZE(4), .HIDDEN_SIZE(2), .DATA_WIDTH(8)) bus4 ();

  hidden_layer_mac #(.INPUT_SIZE(4), .HIDDEN_SIZE(2), .DATA_WIDTH(8), .ACC_WIDTH(32), .SHIFT(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  hidden_layer_mac #(.INPUT_SIZE(4), .HIDDEN_SIZE(2), .DATA_WIDTH(8), .ACC_WIDTH(32), .SHIFT(4))
    dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  assign bus0.start   = start_s & ~sel;
  assign bus4.start   = start_s &  sel;
  assign bus0.h_ready = ready_s;
  assign bus4.h_ready = ready_s;

  always @(posedge clk) begin
    if (bus0.rd_en) begin
      bus0.x_data <= pix[bus0.x_addr];
      bus0.w_data <= wt[bus0.w_addr];
    end
    if (bus4.rd_en) begin
      bus4.x_data <= pix[bus4.x_addr];
      bus4.w_data <= wt[bus4.w_addr];
    end
  end

  logic       o_busy, o_done, o_rd_en, o_valid;
  logic [1:0] o_x_addr;
  logic [2:0] o_w_addr;
  logic [7:0] o_data;
  logic [0:0] o_index;

  assign o_busy   = sel ? bus4.busy    : bus0.busy;
  assign o_done   = sel ? bus4.done    : bus0.done;
  assign o_rd_en  = sel ? bus4.rd_en   : bus0.rd_en;
  assign o_valid  = sel ? bus4.h_valid : bus0.h_valid;
  assign o_x_addr = sel ? bus4.x_addr  : bus0.x_addr;
  assign o_w_addr = sel ? bus4.w_addr  : bus0.w_addr;
  assign o_data   = sel ? bus4.h_data  : bus0.h_data;
  assign o_index  = sel ? bus4.h_index : bus0.h_index;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},    32'(o_busy),   0);
    check({tag, " done"},    32'(o_done),   0);
    check({tag, " rd_en"},   32'(o_rd_en),  0);
    check({tag, " x_addr"},  32'(o_x_addr), 0);
    check({tag, " w_addr"},  32'(o_w_addr), 0);
    check({tag, " h_valid"}, 32'(o_valid),  0);
    check({tag, " h_data"},  32'(o_data),   0);
    check({tag, " h_index"}, 32'(o_index),  0);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 4; i++) pix[i] = 8'(i + 1);
    for (int i = 0; i < 8; i++) wt[i] = (i % 2 == 0) ? 8'd1 : 8'hFF;
  endtask

  // Runs one image with h_ready held high; called and returns at a negedge.
  task automatic run_image(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input bit poke);
    int         cyc, done_cyc, n_emit, n_rd;
    logic [7:0] d  [2];
    logic [0:0] ix [2];
    logic [1:0] xa [8];
    logic [2:0] wa [8];
    ready_s = 1'b1;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    check({tag, " busy after start"}, 32'(o_busy), 1);
    cyc = 1; done_cyc = -1; n_emit = 0; n_rd = 0;
    while (cyc <= 40 && done_cyc < 0) begin
      if (o_rd_en) begin
        if (n_rd < 8) begin xa[n_rd] = o_x_addr; wa[n_rd] = o_w_addr; end
        n_rd++;
      end
      if (o_valid && ready_s) begin
        if (n_emit < 2) begin d[n_emit] = o_data; ix[n_emit] = o_index; end
        n_emit++;
      end
      if (o_done) done_cyc = cyc;
      start_s = poke && (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    check({tag, " done cycle"}, 32'(done_cyc), 13);
    check({tag, " done one cycle"}, 32'(o_done), 0);
    check({tag, " idle after done"}, 32'(o_busy), 0);
    check({tag, " emit count"}, 32'(n_emit), 2);
    check({tag, " read count"}, 32'(n_rd), 8);
    if (n_emit >= 2) begin
      check({tag, " index0"}, 32'(ix[0]), 0);
      check({tag, " data0"},  32'(d[0]),  32'(e0));
      check({tag, " index1"}, 32'(ix[1]), 1);
      check({tag, " data1"},  32'(d[1]),  32'(e1));
    end
    if (n_rd >= 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("%s x_addr[%0d]", tag, i), 32'(xa[i]), 32'(i % 4));
        check($sformatf("%s w_addr[%0d]", tag, i), 32'(wa[i]), 32'((i % 4) * 2 + i / 4));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc;
    logic [7:0] d1;
    logic [0:0] i1;
    logic       seen;

    load_basic();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // Basic image, with a stray start pulse mid-RUN that must be ignored.
    run_image("basic", 8'd10, 8'd0, 1'b1);

    // Backpressure: hold off the first activation for five EMIT cycles.
    ready_s = 1'b0;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    cyc = 1;
    while (!o_valid && cyc < 20) begin @(negedge clk); cyc++; end
    check("bp valid", 32'(o_valid), 1);
    check("bp emit cycle", 32'(cyc), 6);
    repeat (5) begin
      @(negedge clk);
      check("bp hold valid", 32'(o_valid), 1);
      check("bp hold data",  32'(o_data),  10);
      check("bp hold index", 32'(o_index), 0);
      check("bp hold rd_en", 32'(o_rd_en), 0);
    end
    ready_s = 1'b1;
    @(negedge clk);
    check("bp resume rd_en",  32'(o_rd_en),  1);
    check("bp resume x_addr", 32'(o_x_addr), 0);
    check("bp resume w_addr", 32'(o_w_addr), 1);
    seen = 1'b0; d1 = '1; i1 = '0; cyc = 0;
    while (!o_done && cyc < 20) begin
      if (o_valid) begin d1 = o_data; i1 = o_index; seen = 1'b1; end
      @(negedge clk);
      cyc++;
    end
    check("bp done", 32'(o_done), 1);
    check("bp second seen", 32'(seen), 1);
    check("bp second index", 32'(i1), 1);
    check("bp second data", 32'(d1), 0);
    @(negedge clk);

    // Saturation: positive overflow clamps to 255, negative sums clamp to 0.
    for (int i = 0; i < 4; i++) pix[i] = 8'd255;
    for (int i = 0; i < 8; i++) wt[i] = 8'd127;
    run_image("sat_pos", 8'd255, 8'd255, 1'b0);
    for (int i = 0; i < 8; i++) wt[i] = 8'h80;
    run_image("sat_neg", 8'd0, 8'd0, 1'b0);

    // SHIFT=4 engine: acc 160 -> 10, acc 10 -> 0.
    sel = 1'b1;
    for (int i = 0; i < 4; i++) pix[i] = 8'(i + 1);
    for (int i = 0; i < 8; i++) wt[i] = (i % 2 == 0) ? 8'd16 : 8'd1;
    run_image("shift4", 8'd10, 8'd0, 1'b0);
    sel = 1'b0;

    // Reset at k=2 of neuron 1, then a clean rerun of the basic image.
    load_basic();
    ready_s = 1'b1;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    cyc = 1;
    while (!(o_rd_en && o_w_addr == 3'd5) && cyc < 20) begin @(negedge clk); cyc++; end
    check("rst point reached", 32'(o_w_addr), 5);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    run_image("rerun", 8'd10, 8'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
